bounded_counter: RTL

//  Parametrised up/down counter that never leaves a programmable range [MIN_VAL, MAX_VAL].

---
 rtl/bounded_counter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/bounded_counter.sv
// bounded_counter: parametrised up/down counter confined to [MIN_VAL, MAX_VAL].
// Features: wrap or saturate at the bounds, synchronous clear and clamped load,
// an enable prescaler, a registered wrap pulse (tc), a sticky saturation flag
// and a registered load-clamp pulse. There is no handshake on this block; every
// input is sampled on each rising clock edge.
module bounded_counter #(
   parameter int WIDTH    = 8,
   parameter int MIN_VAL  = 0,
   parameter int MAX_VAL  = 100,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             up_dn,
   input  logic             wrap_mode,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] counter,
   output logic             at_max,
   output logic             at_min,
   output logic             tc,
   output logic             sat_hit,
   output logic             load_err
);

   // Prescaler width: at least one bit so PRESCALE=1 still elaborates cleanly.
   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   // Bounds widened by one bit so that MAX_VAL = 2**WIDTH-1 cannot overflow
   // when incremented or compared.
   localparam logic [WIDTH:0]   MIN_X = (WIDTH + 1)'(MIN_VAL);
   localparam logic [WIDTH:0]   MAX_X = (WIDTH + 1)'(MAX_VAL);
   localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

   logic [PS_W-1:0]  ps_cnt;
   logic [PS_W-1:0]  ps_next;
   logic             step;

   logic [WIDTH:0]   cnt_x;
   logic [WIDTH:0]   lv_x;
   logic [WIDTH:0]   cnt_next_x;
   logic [WIDTH-1:0] counter_next;
   logic             tc_next;
   logic             sat_next;
   logic             load_err_next;

   assign cnt_x = {1'b0, counter};
   assign lv_x  = {1'b0, load_val};

   // Prescaler: counts enabled clocks and fires step on the last one; any
   // clear, load or dropped enable discards the partial count.
   always_comb begin
      ps_next = ps_cnt;
      step    = 1'b0;
      if (clear || load || !enable) begin
         ps_next = '0;
      end else if (ps_cnt == PS_LAST) begin
         ps_next = '0;
         step    = 1'b1;
      end else begin
         ps_next = ps_cnt + PS_W'(1);
      end
   end

   // Next count and flag values, honouring clear > load > step priority.
   always_comb begin
      cnt_next_x    = cnt_x;
      tc_next       = 1'b0;
      sat_next      = sat_hit;
      load_err_next = 1'b0;
      if (clear) begin
         cnt_next_x = MIN_X;
         sat_next   = 1'b0;
      end else if (load) begin
         if (lv_x > MAX_X) begin
            cnt_next_x    = MAX_X;
            load_err_next = 1'b1;
         end else if (lv_x < MIN_X) begin
            cnt_next_x    = MIN_X;
            load_err_next = 1'b1;
         end else begin
            cnt_next_x = lv_x;
         end
      end else if (step) begin
         if (up_dn) begin
            if (cnt_x < MAX_X) begin
               cnt_next_x = cnt_x + (WIDTH + 1)'(1);
            end else if (wrap_mode) begin
               cnt_next_x = MIN_X;
               tc_next    = 1'b1;
            end else begin
               sat_next = 1'b1;
            end
         end else begin
            if (cnt_x > MIN_X) begin
               cnt_next_x = cnt_x - (WIDTH + 1)'(1);
            end else if (wrap_mode) begin
               cnt_next_x = MAX_X;
               tc_next    = 1'b1;
            end else begin
               sat_next = 1'b1;
            end
         end
      end
   end

   // Final range guard: whatever the path above produced, the register can
   // only ever take a value inside [MIN_VAL, MAX_VAL].
   always_comb begin
      if (cnt_next_x > MAX_X) begin
         counter_next = MAX_W;
      end else if (cnt_next_x < MIN_X) begin
         counter_next = MIN_W;
      end else begin
         counter_next = cnt_next_x[WIDTH-1:0];
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         counter  <= MIN_W;
         ps_cnt   <= '0;
         tc       <= 1'b0;
         sat_hit  <= 1'b0;
         load_err <= 1'b0;
      end else begin
         counter  <= counter_next;
         ps_cnt   <= ps_next;
         tc       <= tc_next;
         sat_hit  <= sat_next;
         load_err <= load_err_next;
      end
   end

   // Bound indicators decoded straight from the count register.
   always_comb begin
      at_max = (counter == MAX_W);
      at_min = (counter == MIN_W);
   end

endmodule
